// File: rtl/ucaspian_pkt_pkg.sv
// Shared opcodes, FSM state and arbitration source types for the uCaspian
// outbound packet encoder.
package ucaspian_pkt_pkg;

  localparam logic [7:0] PKT_FIRE      = 8'h01;
  localparam logic [7:0] PKT_TIME      = 8'h02;
  localparam logic [7:0] PKT_METRIC    = 8'h03;
  localparam logic [7:0] PKT_CLEAR_ACK = 8'h04;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_state_t;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_CLEAR,
    SRC_METRIC,
    SRC_TIME,
    SRC_FIRE
  } tx_src_t;

  function automatic logic [7:0] src_opcode(input tx_src_t src);
    logic [7:0] op;
    op = '0;
    case (src)
      SRC_CLEAR:  op = PKT_CLEAR_ACK;
      SRC_METRIC: op = PKT_METRIC;
      SRC_TIME:   op = PKT_TIME;
      SRC_FIRE:   op = PKT_FIRE;
      default:    op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ucaspian_packet_tx.sv
// Outbound packet encoder: arbitrates core events and serializes each into a
// byte packet on a ready/valid stream, returning the core-side *_sent pulses.
module ucaspian_packet_tx
  import ucaspian_pkt_pkg::*;
#(
  parameter int unsigned TIME_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  output_fire_addr,
  input  logic        output_fire_waiting,
  output logic        output_fire_sent,
  input  logic [31:0] time_current,
  input  logic        time_update,
  output logic        time_sent,
  input  logic [7:0]  metric_value,
  input  logic        metric_send,
  input  logic        clear_done,
  output logic        ack_sent,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        tx_busy,
  output logic        metric_overflow
);

  localparam int unsigned TIME_SHIFT = 32 - 8 * TIME_BYTES;

  tx_state_t   state_q;
  logic [39:0] shift_q;
  logic [2:0]  rem_q;
  logic [7:0]  tx_data_q;
  logic        tx_vld_q;
  logic        fire_sent_q;
  logic        time_sent_q;
  logic        ack_sent_q;
  logic [7:0]  metric_q;
  logic        metric_pend_q;
  logic        metric_ovf_q;

  tx_src_t     grant_src;
  logic [39:0] grant_payload;
  logic [2:0]  grant_len;
  logic [31:0] time_aligned;
  logic        grant_metric;

  // Payload is MSB-aligned so every packet type shifts out from bits [39:32].
  always_comb begin
    grant_src     = SRC_NONE;
    grant_payload = '0;
    grant_len     = '0;
    time_aligned  = time_current << TIME_SHIFT;
    if (state_q == IDLE) begin
      if (clear_done) begin
        grant_src = SRC_CLEAR;
      end else if (metric_pend_q) begin
        grant_src     = SRC_METRIC;
        grant_payload = {metric_q, 32'h0};
        grant_len     = 3'd1;
      end else if (time_update) begin
        grant_src     = SRC_TIME;
        grant_payload = {time_aligned, 8'h00};
        grant_len     = 3'(TIME_BYTES);
      end else if (output_fire_waiting) begin
        grant_src     = SRC_FIRE;
        grant_payload = {output_fire_addr, 32'h0};
        grant_len     = 3'd1;
      end
    end
    grant_metric = (grant_src == SRC_METRIC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      rem_q         <= '0;
      tx_data_q     <= '0;
      tx_vld_q      <= 1'b0;
      fire_sent_q   <= 1'b0;
      time_sent_q   <= 1'b0;
      ack_sent_q    <= 1'b0;
      metric_q      <= '0;
      metric_pend_q <= 1'b0;
      metric_ovf_q  <= 1'b0;
    end else begin
      fire_sent_q <= 1'b0;
      time_sent_q <= 1'b0;
      ack_sent_q  <= 1'b0;

      // A grant frees the holding register in the same cycle a new byte lands.
      if (metric_send) begin
        if (!metric_pend_q || grant_metric) begin
          metric_q      <= metric_value;
          metric_pend_q <= 1'b1;
        end else begin
          metric_ovf_q  <= 1'b1;
        end
      end else if (grant_metric) begin
        metric_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (grant_src != SRC_NONE) begin
            state_q     <= SEND;
            tx_data_q   <= src_opcode(grant_src);
            tx_vld_q    <= 1'b1;
            shift_q     <= grant_payload;
            rem_q       <= grant_len;
            fire_sent_q <= (grant_src == SRC_FIRE);
            time_sent_q <= (grant_src == SRC_TIME);
            ack_sent_q  <= (grant_src == SRC_CLEAR);
          end
        end
        SEND: begin
          if (tx_vld_q && tx_rdy) begin
            if (rem_q != 3'd0) begin
              tx_data_q <= shift_q[39:32];
              shift_q   <= shift_q << 8;
              rem_q     <= rem_q - 3'd1;
            end else begin
              tx_vld_q  <= 1'b0;
              state_q   <= GAP;
            end
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data          = tx_data_q;
  assign tx_vld           = tx_vld_q;
  assign output_fire_sent = fire_sent_q;
  assign time_sent        = time_sent_q;
  assign ack_sent         = ack_sent_q;
  assign metric_overflow  = metric_ovf_q;
  assign tx_busy          = (state_q != IDLE) | metric_pend_q;

endmodule

// File: tb/tb_ucaspian_packet_tx.sv
// Scoreboard bench for ucaspian_packet_tx: expected bytes are queued when a
// request is driven and popped as the stream hands them off.
module tb_ucaspian_packet_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  output_fire_addr;
  logic        output_fire_waiting;
  logic        output_fire_sent;
  logic [31:0] time_current;
  logic        time_update;
  logic        time_sent;
  logic [7:0]  metric_value;
  logic        metric_send;
  logic        clear_done;
  logic        ack_sent;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        tx_busy;
  logic        metric_overflow;

  logic [31:0] time2;
  logic        time_update2;
  logic        fire_sent2, time_sent2, ack_sent2, tx_vld2, tx_busy2, ovf2;
  logic [7:0]  tx_data2;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q[$];
  int unsigned fire_cnt = 0, time_cnt = 0, ack_cnt = 0;
  int unsigned cyc = 0, hs_first = 0, hs_last = 0;
  bit          hs_seen = 0;
  int unsigned rdy_mode = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = '0;
  bit          drop_f = 0, drop_t = 0, drop_a = 0;

  typedef struct {
    int unsigned kind;   // 0 fire, 1 time, 2 metric, 3 clear
    logic [31:0] val;
    int unsigned mode;   // 0 rdy high, 1 rdy toggling
    int unsigned nbytes;
    logic [39:0] bytes;
  } vec_t;
  vec_t vecs[6];

  ucaspian_packet_tx #(.TIME_BYTES(4)) dut (
    .clk(clk), .reset(reset),
    .output_fire_addr(output_fire_addr), .output_fire_waiting(output_fire_waiting),
    .output_fire_sent(output_fire_sent),
    .time_current(time_current), .time_update(time_update), .time_sent(time_sent),
    .metric_value(metric_value), .metric_send(metric_send),
    .clear_done(clear_done), .ack_sent(ack_sent),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .tx_busy(tx_busy), .metric_overflow(metric_overflow)
  );

  ucaspian_packet_tx #(.TIME_BYTES(2)) dut2 (
    .clk(clk), .reset(reset),
    .output_fire_addr(8'h00), .output_fire_waiting(1'b0),
    .output_fire_sent(fire_sent2),
    .time_current(time2), .time_update(time_update2), .time_sent(time_sent2),
    .metric_value(8'h00), .metric_send(1'b0),
    .clear_done(1'b0), .ack_sent(ack_sent2),
    .tx_data(tx_data2), .tx_vld(tx_vld2), .tx_rdy(1'b1),
    .tx_busy(tx_busy2), .metric_overflow(ovf2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ready pattern for the table-driven packets; mode 2 leaves tx_rdy manual.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) tx_rdy = 1'b1;
    else if (rdy_mode == 1) tx_rdy = ~tx_rdy;
  end

  // Core model: level requests drop one cycle after their *_sent pulse.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      drop_f = 0; drop_t = 0; drop_a = 0;
    end else begin
      if (drop_f) output_fire_waiting = 1'b0;
      if (drop_t) time_update = 1'b0;
      if (drop_a) clear_done = 1'b0;
      drop_f = output_fire_sent;
      drop_t = time_sent;
      drop_a = ack_sent;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) check("stall_hold", {tx_vld, tx_data}, {1'b1, prev_data});
      if (tx_vld && tx_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", tx_data, $time);
        end else begin
          check("tx_byte", tx_data, exp_q.pop_front());
        end
        if (!hs_seen) hs_first = cyc;
        hs_seen = 1;
        hs_last = cyc;
      end
      if (output_fire_sent) begin fire_cnt++; check("fire_sent_hdr", {tx_vld, tx_data}, {1'b1, 8'h01}); end
      if (time_sent)        begin time_cnt++; check("time_sent_hdr", {tx_vld, tx_data}, {1'b1, 8'h02}); end
      if (ack_sent)         begin ack_cnt++;  check("ack_sent_hdr",  {tx_vld, tx_data}, {1'b1, 8'h04}); end
      prev_stall = tx_vld && !tx_rdy;
      prev_data  = tx_data;
    end
  end

  task automatic wait_idle(input int unsigned budget, input string name);
    bit ok = 0;
    for (int i = 0; i < int'(budget) && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !output_fire_waiting && !time_update && !clear_done && !tx_busy;
    end
    check(name, {63'h0, ok}, 64'h1);
  endtask

  task automatic wait_time_pulse(input int unsigned target, input string name);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = (time_cnt >= target);
    end
    check(name, {63'h0, ok}, 64'h1);
    tick(1);
  endtask

  task automatic run_req(input int unsigned kind, input logic [31:0] val, input int unsigned mode,
                         input int unsigned nb, input logic [39:0] bytes);
    int unsigned f0, t0, a0;
    logic [23:0] exp_cnt;
    f0 = fire_cnt; t0 = time_cnt; a0 = ack_cnt;
    rdy_mode = mode;
    for (int i = 0; i < int'(nb); i++) exp_q.push_back(bytes[39 - 8*i -: 8]);
    case (kind)
      0: begin output_fire_addr = val[7:0]; output_fire_waiting = 1'b1; end
      1: begin time_current = val; time_update = 1'b1; end
      2: begin metric_value = val[7:0]; metric_send = 1'b1; tick(1); metric_send = 1'b0; end
      default: clear_done = 1'b1;
    endcase
    wait_idle(60, "pkt_done");
    tick(4);
    exp_cnt = {8'(kind == 0), 8'(kind == 1), 8'(kind == 3)};
    check("sent_pulses", {40'h0, 8'(fire_cnt - f0), 8'(time_cnt - t0), 8'(ack_cnt - a0)}, {40'h0, exp_cnt});
    rdy_mode = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got2[3];
    int unsigned nb2;

    reset = 1'b1;
    output_fire_addr = '0; output_fire_waiting = 1'b0;
    time_current = '0; time_update = 1'b0;
    metric_value = '0; metric_send = 1'b0;
    clear_done = 1'b0; tx_rdy = 1'b1;
    time2 = '0; time_update2 = 1'b0;

    vecs[0] = '{kind: 0, val: 32'h2A,       mode: 0, nbytes: 2, bytes: 40'h012A000000};
    vecs[1] = '{kind: 1, val: 32'h01020304, mode: 1, nbytes: 5, bytes: 40'h0201020304};
    vecs[2] = '{kind: 3, val: 32'h0,        mode: 0, nbytes: 1, bytes: 40'h0400000000};
    vecs[3] = '{kind: 2, val: 32'h5A,       mode: 1, nbytes: 2, bytes: 40'h035A000000};
    vecs[4] = '{kind: 0, val: 32'hFF,       mode: 1, nbytes: 2, bytes: 40'h01FF000000};
    vecs[5] = '{kind: 1, val: 32'hDEADBEEF, mode: 0, nbytes: 5, bytes: 40'h02DEADBEEF};

    tick(2);
    check("reset_state", {tx_vld, tx_data, output_fire_sent, time_sent, ack_sent, metric_overflow, tx_busy}, '0);
    reset = 1'b0;
    tick(2);

    foreach (vecs[i]) run_req(vecs[i].kind, vecs[i].val, vecs[i].mode, vecs[i].nbytes, vecs[i].bytes);

    // All four sources in one cycle: served in priority order with GAP spacing.
    hs_seen = 0;
    rdy_mode = 0;
    clear_done = 1'b1;
    metric_value = 8'h7F; metric_send = 1'b1;
    time_current = 32'h11223344; time_update = 1'b1;
    output_fire_addr = 8'h99; output_fire_waiting = 1'b1;
    foreach (vecs[i]) if (i < 0) exp_q.push_back(8'h00);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h03); exp_q.push_back(8'h7F);
    exp_q.push_back(8'h02); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    exp_q.push_back(8'h01); exp_q.push_back(8'h99);
    tick(1);
    metric_send = 1'b0;
    wait_idle(100, "simul_done");
    check("simul_span", 64'(hs_last - hs_first), 64'd15);
    check("simul_no_ovf", {63'h0, metric_overflow}, 64'h0);
    tick(4);

    // Two metric bytes while a TIME packet is stalled: second one is dropped.
    rdy_mode = 2; tx_rdy = 1'b0;
    time_current = 32'hA1B2C3D4; time_update = 1'b1;
    exp_q.push_back(8'h02); exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    wait_time_pulse(time_cnt + 1, "ovf_time_grant");
    metric_value = 8'h11; metric_send = 1'b1;
    tick(1);
    metric_value = 8'h22;
    tick(1);
    metric_send = 1'b0;
    exp_q.push_back(8'h03); exp_q.push_back(8'h11);
    tick(2);
    check("ovf_set", {62'h0, metric_overflow, tx_busy}, 64'h3);
    rdy_mode = 0;
    wait_idle(60, "ovf_done");
    check("ovf_sticky", {63'h0, metric_overflow}, 64'h1);
    tick(2);

    // Reset between payload bytes aborts the packet immediately.
    rdy_mode = 2; tx_rdy = 1'b0;
    time_current = 32'h0A0B0C0D; time_update = 1'b1;
    exp_q.push_back(8'h02); exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
    exp_q.push_back(8'h0C); exp_q.push_back(8'h0D);
    wait_time_pulse(time_cnt + 1, "rst_time_grant");
    tx_rdy = 1'b1;
    tick(2);
    tx_rdy = 1'b0;
    tick(1);
    check("rst_mid_pkt", {tx_vld, tx_data}, {1'b1, 8'h0B});
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", {tx_vld, tx_data, output_fire_sent, time_sent, ack_sent, metric_overflow, tx_busy}, '0);
    time_update = 1'b0;
    exp_q.delete();
    tick(2);
    reset = 1'b0;
    tick(2);
    run_req(0, 32'h3C, 0, 2, 40'h013C000000);

    // TIME_BYTES=2 instance: only the two LS bytes go out.
    nb2 = 0;
    got2[0] = '0; got2[1] = '0; got2[2] = '0;
    time2 = 32'hAABBCCDD; time_update2 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (tx_vld2) begin
        if (nb2 < 3) got2[nb2] = tx_data2;
        nb2++;
      end
      if (time_sent2) time_update2 = 1'b0;
    end
    check("tb2_count", 64'(nb2), 64'd3);
    check("tb2_byte0", got2[0], 8'h02);
    check("tb2_byte1", got2[1], 8'hCC);
    check("tb2_byte2", got2[2], 8'hDD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
